// File: rtl/cyclone_ddio_in_deser_if.sv
// Bus bundle for the DDR input deserializer.
// Handshake: dataout_valid is a one-cycle strobe with no back-pressure; the
// consumer must take dataout on the inclock rising edge that follows the
// strobe. dataout holds its value between strobes.
interface cyclone_ddio_in_deser_if #(
    parameter int WIDTH = 8
);
    logic             inclocken;
    logic             datain;
    logic             bitslip;
    logic             dataout_h;
    logic             dataout_l;
    logic [WIDTH-1:0] dataout;
    logic             dataout_valid;

    // Driver of the serial stream / consumer of the words
    modport master (
        output inclocken, datain, bitslip,
        input  dataout_h, dataout_l, dataout, dataout_valid
    );

    // The deserializer itself
    modport slave (
        input  inclocken, datain, bitslip,
        output dataout_h, dataout_l, dataout, dataout_valid
    );
endinterface

// File: rtl/cyclone_ddio_in_deser.sv
// DDR input capture plus deserializer for a Cyclone I/O combout.
// A bit is captured on each clock edge, the pair is realigned into the
// rising-edge domain, shifted into a history register and emitted as a
// WIDTH-bit word (first-arriving bit at MSB). bitslip moves the word
// boundary one bit later per rising-edge event, using a pair-count stall
// plus a one-bit window offset (phase).
// WIDTH must be even, 4..16.
module cyclone_ddio_in_deser #(
    parameter int WIDTH = 8
) (
    input  logic                      inclock,
    input  logic                      aclr_n,
    cyclone_ddio_in_deser_if.slave    bus
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic             en_q;          // enable sampled at the rising edge, used by the falling capture
    logic             h_cap;
    logic             l_neg;
    logic             out_h;
    logic             out_l;
    // Only the bits that either word window can still reach are kept;
    // the top of the full shift image falls out of every window.
    logic [WIDTH-2:0] sr_hist;
    logic [CW-1:0]    pair_cnt;
    logic [1:0]       prime_cnt;
    logic             phase;
    logic             bitslip_q;
    logic             pending_stall;
    logic [WIDTH-1:0] word;
    logic             word_valid;

    logic             slip;
    logic             primed;
    logic             stall;
    logic             terminal;
    logic             phase_next;
    logic [WIDTH:0]   sr_next;

    assign bus.dataout_h     = out_h;
    assign bus.dataout_l     = out_l;
    assign bus.dataout       = word;
    assign bus.dataout_valid = word_valid;

    // Slip detection, stall decision and post-shift image for this edge
    always_comb begin
        slip       = bus.bitslip & ~bitslip_q;
        primed     = (prime_cnt == 2'd2);
        stall      = primed & (pending_stall | (slip & ~phase));
        terminal   = primed & ~stall & (pair_cnt == LAST);
        phase_next = slip ? ~phase : phase;
        sr_next    = {sr_hist, out_h, out_l};
    end

    // Falling-edge capture of the second bit of each pair
    always_ff @(negedge inclock or negedge aclr_n) begin
        if (!aclr_n) begin
            l_neg <= 1'b0;
        end else if (en_q) begin
            l_neg <= bus.datain;
        end
    end

    // Rising-edge capture, realignment, shifting, slip handling and word output
    always_ff @(posedge inclock or negedge aclr_n) begin
        if (!aclr_n) begin
            en_q          <= 1'b0;
            h_cap         <= 1'b0;
            out_h         <= 1'b0;
            out_l         <= 1'b0;
            sr_hist       <= '0;
            pair_cnt      <= '0;
            prime_cnt     <= 2'd0;
            phase         <= 1'b0;
            bitslip_q     <= 1'b0;
            pending_stall <= 1'b0;
            word          <= '0;
            word_valid    <= 1'b0;
        end else begin
            en_q <= bus.inclocken;
            if (bus.inclocken) begin
                h_cap     <= bus.datain;
                out_h     <= h_cap;
                out_l     <= l_neg;
                bitslip_q <= bus.bitslip;
                phase     <= phase_next;
                if (!primed) begin
                    // Realignment path still holds reset zeros: no shifting yet
                    prime_cnt <= prime_cnt + 2'd1;
                    if (slip && !phase) begin
                        pending_stall <= 1'b1;
                    end
                end else begin
                    sr_hist       <= sr_next[WIDTH-2:0];
                    pending_stall <= 1'b0;
                    if (!stall) begin
                        pair_cnt <= terminal ? '0 : pair_cnt + CW'(1);
                    end
                end
                if (terminal) begin
                    word <= phase_next ? sr_next[WIDTH:1] : sr_next[WIDTH-1:0];
                end
                word_valid <= terminal;
            end else begin
                word_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cyclone_ddio_in_deser.sv
// Bench for cyclone_ddio_in_deser (WIDTH=8). The reference model numbers
// every enabled bit in arrival order and tracks the index of the last bit
// of the next word; each slip event moves that index one bit later, and a
// word ending at bit E is emitted on enabled rising edge E/2 + 2.
module tb_cyclone_ddio_in_deser;
    localparam int WIDTH = 8;

    logic inclock = 1'b0;
    logic aclr_n  = 1'b1;

    cyclone_ddio_in_deser_if #(.WIDTH(WIDTH)) bus ();

    cyclone_ddio_in_deser #(.WIDTH(WIDTH)) dut (
        .inclock (inclock),
        .aclr_n  (aclr_n),
        .bus     (bus)
    );

    // Clock
    always #5 inclock = ~inclock;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int               m_e;        // enabled rising edges since reset
    int               m_end;      // bit index of the last bit of the next word
    logic             m_slip_q;
    logic             bits_mem [0:8191];
    logic             exp_h;
    logic             exp_l;
    logic [WIDTH-1:0] exp_word;

    // Pattern stream state
    logic [7:0] pat;
    int         pos;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_e      = 0;
        m_end    = WIDTH - 1;
        m_slip_q = 1'b0;
        exp_h    = 1'b0;
        exp_l    = 1'b0;
        exp_word = '0;
    endtask

    // Called just after a falling edge; drives one rising/falling pair and checks
    task automatic drive_cycle(input logic h, input logic l, input logic en, input logic slip);
        logic exp_valid;
        exp_valid     = 1'b0;
        bus.datain    = h;
        bus.inclocken = en;
        bus.bitslip   = slip;
        @(posedge inclock);
        #1;
        if (en) begin
            if (slip && !m_slip_q) m_end = m_end + 1;
            m_slip_q = slip;
            if (m_e >= 1) begin
                exp_h = bits_mem[2*m_e-2];
                exp_l = bits_mem[2*m_e-1];
            end
            bits_mem[2*m_e]   = h;
            bits_mem[2*m_e+1] = l;
            if (m_e == m_end / 2 + 2) begin
                exp_valid = 1'b1;
                for (int i = 0; i < WIDTH; i++)
                    exp_word[WIDTH-1-i] = bits_mem[m_end-WIDTH+1+i];
                m_end = m_end + WIDTH;
            end
            m_e = m_e + 1;
        end
        check_eq("valid", 16'(bus.dataout_valid), 16'(exp_valid));
        check_eq("dataout", 16'(bus.dataout), 16'(exp_word));
        check_eq("dataout_h", 16'(bus.dataout_h), 16'(exp_h));
        check_eq("dataout_l", 16'(bus.dataout_l), 16'(exp_l));
        #1;
        bus.datain = l;
        @(negedge inclock);
        #1;
    endtask

    // Next pair from the repeating pattern byte
    task automatic pat_cycle(input logic en, input logic slip);
        drive_cycle(pat[7-pos], pat[6-pos], en, slip);
        if (en) pos = (pos + 2) % 8;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int k = 0; k < 4; k++)
            drive_cycle(w[7-2*k], w[6-2*k], 1'b1, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_dout"}, 16'(bus.dataout), 16'h0);
        check_eq({tag, "_valid"}, 16'(bus.dataout_valid), 16'h0);
        check_eq({tag, "_h"}, 16'(bus.dataout_h), 16'h0);
        check_eq({tag, "_l"}, 16'(bus.dataout_l), 16'h0);
    endtask

    // Reset pulse between edges (called just after a falling edge)
    task automatic reset_pulse();
        aclr_n = 1'b0;
        #1;
        check_all_zero("rst_pulse");
        #1;
        aclr_n = 1'b1;
        model_reset();
        pos = 0;
    endtask

    task automatic random_run(input int n, input int slip_odds, input int en_odds);
        for (int c = 0; c < n; c++)
            drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, en_odds) != 0),
                        ($urandom_range(0, slip_odds) == 0));
    endtask

    // Stimulus
    initial begin
        bus.inclocken = 1'b1;
        bus.datain    = 1'b0;
        bus.bitslip   = 1'b0;
        pat = 8'hB2;
        pos = 0;
        model_reset();
        aclr_n = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge inclock);
        @(negedge inclock);
        #1;
        aclr_n = 1'b1;

        // First word and continuous stream
        send_word(8'hB2);
        send_word(8'h5A);
        send_word(8'hFF);
        for (int i = 0; i < 8; i++) send_word(8'($urandom_range(0, 255)));

        // Steady B2 stream with slips
        pat = 8'hB2;
        pos = 0;
        for (int i = 0; i < 8; i++) pat_cycle(1'b1, 1'b0);
        pat_cycle(1'b1, 1'b1);
        for (int i = 0; i < 14; i++) pat_cycle(1'b1, 1'b0);
        pat_cycle(1'b1, 1'b1);
        for (int i = 0; i < 14; i++) pat_cycle(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) pat_cycle(1'b1, 1'b1);
        for (int i = 0; i < 14; i++) pat_cycle(1'b1, 1'b0);

        // Slip landing on every position relative to the word boundary
        for (int off = 0; off < 8; off++) begin
            for (int i = 0; i < off; i++) pat_cycle(1'b1, 1'b0);
            pat_cycle(1'b1, 1'b1);
            for (int i = 0; i < 9; i++) pat_cycle(1'b1, 1'b0);
        end

        // Enable low mid-word
        pat_cycle(1'b1, 1'b0);
        pat_cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) pat_cycle(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) pat_cycle(1'b1, 1'b0);

        // Reset mid-word, then re-prime
        pat_cycle(1'b1, 1'b0);
        reset_pulse();
        pat = 8'h5A;
        for (int i = 0; i < 12; i++) pat_cycle(1'b1, 1'b0);

        // Slip before priming completes, on each pre-prime and first-shift edge
        for (int s = 0; s < 3; s++) begin
            pat_cycle(1'b1, 1'b0);
            reset_pulse();
            for (int i = 0; i < s; i++) pat_cycle(1'b1, 1'b0);
            pat_cycle(1'b1, 1'b1);
            for (int i = 0; i < 12; i++) pat_cycle(1'b1, 1'b0);
        end

        // Randomized traffic
        random_run(400, 6, 0);
        random_run(400, 5, 4);
        pat_cycle(1'b1, 1'b0);
        reset_pulse();
        random_run(300, 3, 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
